// File: rtl/seg_scan_driver_if.sv
// Display driver bus: value/point/sign/enable towards the driver, scanned digit drive back.
interface seg_scan_driver_if;
    logic [19:0] data;
    logic [5:0]  point;
    logic        en;
    logic        sign;
    logic [5:0]  seg_sel;
    logic [7:0]  seg_led;

    modport master (
        output data, point, en, sign,
        input  seg_sel, seg_led
    );

    modport slave (
        input  data, point, en, sign,
        output seg_sel, seg_led
    );
endinterface

// File: rtl/seg_scan_driver.sv
// Six-digit multiplexed 7-segment driver with continuous binary-to-BCD conversion.
// Latency: 22-cycle conversion loop, outputs registered one cycle after index; no backpressure.
module seg_scan_driver #(
    parameter int CLK_DIV = 50000
) (
    input  logic              clk,
    input  logic              rst,
    seg_scan_driver_if.slave  bus
);
    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t      state_q, state_d;
    logic [19:0] bin_q, bin_d;
    logic [23:0] bcd_q, bcd_d, adj;
    logic [4:0]  cnt_q, cnt_d;
    logic [5:0]  pt_cap_q, pt_cap_d;
    logic        sign_cap_q, sign_cap_d;
    logic        disp_ld;

    logic [23:0] disp_bcd;
    logic [5:0]  disp_pt;
    logic        disp_sign;

    logic [DW-1:0] div_q;
    logic [2:0]    idx_q;
    logic          tick;

    logic [2:0]  hi;
    logic [3:0]  cur_dig;
    logic        cur_pt;
    logic [7:0]  led_d;
    logic [5:0]  sel_d;
    logic [5:0]  sel_q;
    logic [7:0]  led_q;

    function automatic logic [7:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 8'hC0;
            4'd1:    seg7 = 8'hF9;
            4'd2:    seg7 = 8'hA4;
            4'd3:    seg7 = 8'hB0;
            4'd4:    seg7 = 8'h99;
            4'd5:    seg7 = 8'h92;
            4'd6:    seg7 = 8'h82;
            4'd7:    seg7 = 8'hF8;
            4'd8:    seg7 = 8'h80;
            4'd9:    seg7 = 8'h90;
            default: seg7 = 8'hFF;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            bin_q      <= '0;
            bcd_q      <= '0;
            cnt_q      <= '0;
            pt_cap_q   <= '0;
            sign_cap_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            bin_q      <= bin_d;
            bcd_q      <= bcd_d;
            cnt_q      <= cnt_d;
            pt_cap_q   <= pt_cap_d;
            sign_cap_q <= sign_cap_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        bin_d      = bin_q;
        bcd_d      = bcd_q;
        cnt_d      = cnt_q;
        pt_cap_d   = pt_cap_q;
        sign_cap_d = sign_cap_q;
        disp_ld    = 1'b0;
        adj        = bcd_q;
        for (int n = 0; n < 6; n++) begin
            if (adj[4*n +: 4] >= 4'd5) adj[4*n +: 4] = adj[4*n +: 4] + 4'd3;
        end
        case (state_q)
            IDLE: begin
                bin_d      = (bus.data > 20'd999999) ? 20'd999999 : bus.data;
                bcd_d      = '0;
                cnt_d      = '0;
                pt_cap_d   = bus.point;
                sign_cap_d = bus.sign;
                state_d    = SHIFT;
            end
            SHIFT: begin
                {bcd_d, bin_d} = {adj[22:0], bin_q, 1'b0};
                cnt_d          = cnt_q + 5'd1;
                if (cnt_q == 5'd19) state_d = DONE;
            end
            DONE: begin
                disp_ld = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            disp_bcd  <= '0;
            disp_pt   <= '0;
            disp_sign <= 1'b0;
        end else if (disp_ld) begin
            disp_bcd  <= bcd_q;
            disp_pt   <= pt_cap_q;
            disp_sign <= sign_cap_q;
        end
    end

    assign tick = (div_q == DW'(CLK_DIV - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            div_q <= '0;
            idx_q <= '0;
        end else if (tick) begin
            div_q <= '0;
            idx_q <= (idx_q == 3'd5) ? 3'd0 : idx_q + 3'd1;
        end else begin
            div_q <= div_q + DW'(1);
        end
    end

    // hi is the highest non-zero digit; digit 0 is never blanked even when all digits are zero
    always_comb begin
        hi      = 3'd0;
        cur_dig = 4'd0;
        cur_pt  = 1'b0;
        for (int j = 0; j < 6; j++) begin
            if (disp_bcd[4*j +: 4] != 4'd0) hi = 3'(j);
            if (idx_q == 3'(j)) begin
                cur_dig = disp_bcd[4*j +: 4];
                cur_pt  = disp_pt[j];
            end
        end
        if (idx_q <= hi)
            led_d = seg7(cur_dig);
        else if (disp_sign && hi != 3'd5 && idx_q == hi + 3'd1)
            led_d = 8'hBF;
        else
            led_d = 8'hFF;
        if (cur_pt) led_d[7] = 1'b0;
        sel_d = ~(6'b1 << idx_q);
        if (!bus.en) begin
            sel_d = 6'h3F;
            led_d = 8'hFF;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sel_q <= 6'h3F;
            led_q <= 8'hFF;
        end else begin
            sel_q <= sel_d;
            led_q <= led_d;
        end
    end

    assign bus.seg_sel = sel_q;
    assign bus.seg_led = led_q;
endmodule

// File: tb/tb_seg_scan_driver.sv
// Randomized and directed bench for seg_scan_driver against a decimal-arithmetic display model.
module tb_seg_scan_driver;
    localparam int CLK_DIV = 4;

    typedef logic [7:0] tbl_t [6];

    logic clk = 1'b0;
    logic rst;

    seg_scan_driver_if bus();

    seg_scan_driver #(.CLK_DIV(CLK_DIV)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_bad = 0;
    int          k = 0;
    int unsigned m_val = 0, c_val = 0;
    logic [5:0]  m_pt = '0, c_pt = '0;
    logic        m_sg = 1'b0, c_sg = 1'b0;
    logic [5:0]  e_sel;
    logic [7:0]  e_led;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s at t=%0t: got %02h expected %02h", tag, $time, got, exp);
        end
    endtask

    function automatic logic [7:0] seg7(input int d);
        case (d)
            0: seg7 = 8'hC0;  1: seg7 = 8'hF9;  2: seg7 = 8'hA4;  3: seg7 = 8'hB0;
            4: seg7 = 8'h99;  5: seg7 = 8'h92;  6: seg7 = 8'h82;  7: seg7 = 8'hF8;
            8: seg7 = 8'h80;  9: seg7 = 8'h90;
            default: seg7 = 8'hFF;
        endcase
    endfunction

    function automatic logic [7:0] m_code(input int unsigned val, input logic [5:0] pt,
                                          input logic sg, input int i);
        int d [6];
        int h = 0;
        int unsigned v = val;
        logic [7:0] c;
        for (int j = 0; j < 6; j++) begin
            d[j] = int'(v % 10);
            v = v / 10;
            if (d[j] != 0) h = j;
        end
        if (i <= h)                         c = seg7(d[i]);
        else if (sg && h < 5 && i == h + 1) c = 8'hBF;
        else                                c = 8'hFF;
        if (pt[i]) c[7] = 1'b0;
        return c;
    endfunction

    // One clock: the model advances from the inputs present at the edge, then outputs are checked
    task automatic step();
        int idx_prev;
        @(posedge clk);
        idx_prev = (k / CLK_DIV) % 6;
        if (rst) begin
            k = 0;  m_val = 0;  m_pt = '0;  m_sg = 1'b0;
            e_sel = 6'h3F;  e_led = 8'hFF;
        end else begin
            if (!bus.en) begin
                e_sel = 6'h3F;  e_led = 8'hFF;
            end else begin
                e_sel = ~(6'b1 << idx_prev);
                e_led = m_code(m_val, m_pt, m_sg, idx_prev);
            end
            k++;
            if (k % 22 == 1) begin
                c_val = (bus.data > 20'd999999) ? 999999 : int'(bus.data);
                c_pt  = bus.point;
                c_sg  = bus.sign;
            end else if (k % 22 == 0) begin
                m_val = c_val;  m_pt = c_pt;  m_sg = c_sg;
            end
        end
        #1;
        check("seg_sel", {2'b00, bus.seg_sel}, {2'b00, e_sel});
        check("seg_led", bus.seg_led, e_led);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic scan_table(input tbl_t t);
        for (int c = 0; c < 6 * CLK_DIV; c++) begin
            step();
            for (int i = 0; i < 6; i++)
                if (bus.seg_sel == ~(6'b1 << i)) check("digit", bus.seg_led, t[i]);
        end
    endtask

    task automatic wait_phase(input int ph);
        for (int i = 0; i < 22 && (k % 22) != ph; i++) step();
    endtask

    tbl_t t;

    initial begin
        rst = 1'b1;
        bus.data = 20'd123456;  bus.point = '0;  bus.en = 1'b1;  bus.sign = 1'b0;
        step();
        step();
        rst = 1'b0;

        run(50);
        wait_phase(3);
        t = '{8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9};
        scan_table(t);

        bus.data = 20'd42;  bus.sign = 1'b1;  bus.point = 6'b000010;
        run(50);
        t = '{8'hA4, 8'h19, 8'hBF, 8'hFF, 8'hFF, 8'hFF};
        scan_table(t);

        bus.data = 20'd0;  bus.sign = 1'b0;  bus.point = '0;
        run(50);
        t = '{8'hC0, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        scan_table(t);

        bus.data = 20'd1048575;
        run(50);
        t = '{8'h90, 8'h90, 8'h90, 8'h90, 8'h90, 8'h90};
        scan_table(t);

        run(6);
        bus.en = 1'b0;
        run(10);
        bus.en = 1'b1;
        run(24);

        bus.data = 20'd100;
        run(50);
        wait_phase(5);
        bus.data = 20'd200;
        wait_phase(0);
        run(30);

        wait_phase(11);
        rst = 1'b1;
        step();
        rst = 1'b0;
        run(50);

        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                bus.data  = 20'($urandom_range(0, 1048575));
                bus.point = 6'($urandom_range(0, 63));
                bus.sign  = 1'($urandom_range(0, 1));
            end
            if ($urandom_range(0, 3) == 0) bus.data = 20'($urandom_range(0, 999));
            bus.en = ($urandom_range(0, 15) != 0);
            rst    = ($urandom_range(0, 149) == 0);
            step();
        end
        rst = 1'b0;
        bus.en = 1'b1;
        run(50);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
